// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO, standard (1-cycle read latency) or FWFT (head presented) read mode.
// Writes into a full FIFO succeed only alongside an accepted read; rejected requests set sticky errors.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rvalid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_T = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_T = (AW+1)'(AE_THRESH);
    localparam logic [AW:0] FULL_T = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [AW:0]           wr_ptr_n, rd_ptr_n, count_n;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] head_n;

    assign rd_acc   = rd_en & ~empty;
    assign wr_acc   = wr_en & (~full | rd_acc);
    assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, wr_acc};
    assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, rd_acc};
    assign count_n  = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

    // Next head for FWFT: when the new head is the word being written this edge, bypass the array.
    always_comb begin
        head_n = rdata;
        if (count_n != '0) begin
            if (rd_ptr_n == wr_ptr) begin
                head_n = wdata;
            end else begin
                head_n = mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            count        <= count_n;
            full         <= (count_n == FULL_T);
            empty        <= (count_n == '0);
            almost_full  <= (count_n >= AF_T);
            almost_empty <= (count_n <= AE_T);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (FWFT != 0) begin
            rdata  <= head_n;
            rvalid <= (count_n != '0);
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // An error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both against a queue model.
module tb_sync_fifo_fwft;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] wdata;

    logic [7:0] rdata0, rdata1;
    logic       rvalid0, rvalid1, full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
    logic [4:0] count0, count1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0), .clr_err(clr_err)
    );

    sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1), .clr_err(clr_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the FIFO is a queue; read mode only changes what rdata/rvalid show.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0, s_rvalid = 1'b0;
    logic [7:0] s_rdata = 8'h00, f_rdata = 8'h00;
    bit         racc, wacc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; s_rvalid = 1'b0;
            s_rdata = 8'h00; f_rdata = 8'h00;
        end else begin
            racc = rd_en && (q.size() > 0);
            wacc = wr_en && ((q.size() < DEPTH) || racc);
            s_rvalid = racc;
            if (racc) s_rdata = q.pop_front();
            if (wacc) q.push_back(wdata);
            if (q.size() > 0) f_rdata = q[0];
            if (wr_en && !wacc) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
            if (rd_en && !racc) m_udf = 1'b1; else if (clr_err) m_udf = 1'b0;
        end
    end

    always @(negedge clk) begin
        int n;
        n = q.size();
        chk("std_rdata", rdata0, s_rdata);
        chk("std_rvalid", rvalid0, s_rvalid);
        chk("fw_rdata", rdata1, f_rdata);
        chk("fw_rvalid", rvalid1, n != 0);
        chk("std_count", count0, n);
        chk("fw_count", count1, n);
        chk("std_full", full0, n == DEPTH);
        chk("fw_full", full1, n == DEPTH);
        chk("std_empty", empty0, n == 0);
        chk("fw_empty", empty1, n == 0);
        chk("std_af", af0, n >= AF);
        chk("fw_af", af1, n >= AF);
        chk("std_ae", ae0, n <= AE);
        chk("fw_ae", ae1, n <= AE);
        chk("std_ovf", ovf0, m_ovf);
        chk("fw_ovf", ovf1, m_ovf);
        chk("std_udf", udf0, m_udf);
        chk("fw_udf", udf1, m_udf);
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en = w; wdata = d; rd_en = r; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_count", count0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_ae", ae0, 1);
        chk("rst_rvalid_fw", rvalid1, 0);

        // Fill and drain
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 13) chk("lit_af_13", af0, 0);
            if (i == 14) chk("lit_af_14", af0, 1);
        end
        chk("lit_full", full0, 1);
        chk("lit_fw_head", rdata1, 8'h01);

        // Overflow
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("lit_ovf_count", count0, 16);
        chk("lit_ovf", ovf0, 1);

        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("lit_drain_data", rdata0, 8'(i));
            chk("lit_drain_rvalid", rvalid0, 1);
            if (i == 14) chk("lit_ae_2", ae0, 1);
        end
        chk("lit_drain_empty", empty0, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lit_rvalid_drop", rvalid0, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("lit_clr_ovf", ovf0, 0);

        // Underflow with simultaneous write
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("lit_udf", udf0, 1);
        chk("lit_udf_count", count0, 1);
        chk("lit_udf_fw", rdata1, 8'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lit_udf_read", rdata0, 8'h55);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous read/write across wraps
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(16 + i), 1'b1, 1'b0);
            chk("lit_rw_data", rdata0, 8'(i));
        end
        chk("lit_rw_full", full0, 1);
        chk("lit_rw_ovf", ovf0, 0);
        drain();

        // FWFT behaviour
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("lit_fw_3c", rdata1, 8'h3C);
        chk("lit_fw_rv", rvalid1, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lit_fw_pop", rvalid1, 0);
        step(1'b1, 8'h40, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'(8'h41 + k), 1'b1, 1'b0);
            chk("lit_fw_stream_rv", rvalid1, 1);
            chk("lit_fw_stream_d", rdata1, 8'(8'h41 + k));
        end
        drain();

        // Randomized traffic, phases biased toward filling, draining, balanced
        for (int k = 0; k < 3000; k++) begin
            int wp, rp;
            case ((k / 300) % 3)
                0: begin wp = 80; rp = 30; end
                1: begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
                 $urandom_range(31) == 0);
        end

        // Reset mid-operation
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("lit_pre_rst_count", count0, 7);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count0, 0);
        chk("mid_rst_empty", empty1, 1);
        chk("mid_rst_full", full0, 0);
        chk("mid_rst_af", af1, 0);
        chk("mid_rst_rdata_std", rdata0, 0);
        chk("mid_rst_rdata_fw", rdata1, 0);
        chk("mid_rst_rvalid", rvalid1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_fw", rdata1, 8'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_std", rdata0, 8'h77);
        chk("post_rst_count", count0, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
